// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI read channel between ICache and DCache.
// One AR at a time; the R burst is gathered into a line buffer and returned with a one-cycle pulse.
module axi_read_arbiter #(
   parameter int         ILINE_BEATS = 8,
   parameter int         DLINE_BEATS = 4,
   parameter logic [3:0] I_ID        = 4'd0,
   parameter logic [3:0] D_ID        = 4'd1
) (
   input  logic         Clk,
   input  logic         Rest,
   input  logic         IReq,
   input  logic         IUncache,
   input  logic [31:0]  IAddr,
   output logic         IGrant,
   output logic         IRespValid,
   input  logic         DReq,
   input  logic         DUncache,
   input  logic [31:0]  DAddr,
   output logic         DGrant,
   output logic         DRespValid,
   output logic [255:0] RespData,
   output logic         RespErr,
   output logic         Busy,
   output logic [3:0]   Arid,
   output logic [31:0]  Araddr,
   output logic [7:0]   Arlen,
   output logic [2:0]   Arsize,
   output logic [1:0]   Arburst,
   output logic         Arvalid,
   input  logic         Arready,
   input  logic [3:0]   Rid,
   input  logic [31:0]  Rdata,
   input  logic [1:0]   Rresp,
   input  logic         Rlast,
   input  logic         Rvalid,
   output logic         Rready
);

   typedef enum logic [1:0] {IDLE, ARREQ, RDATA, RESP} state_e;

   state_e           state_q, state_d;
   logic             owner_q, owner_d;   // 1 = DCache
   logic             last_q, last_d;     // 1 = DCache was granted last
   logic [31:0]      addr_q, addr_d;
   logic [3:0]       exp_q, exp_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             err_q, err_d;
   logic [7:0][31:0] buf_q, buf_d;
   logic [3:0]       own_id;
   logic             unc;

   assign own_id = owner_q ? D_ID : I_ID;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      addr_d  = addr_q;
      exp_d   = exp_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      buf_d   = buf_q;
      unc     = 1'b0;
      case (state_q)
         IDLE: begin
            if (IReq | DReq) begin
               // DCache wins a tie only when ICache was served last
               owner_d = DReq & (~IReq | ~last_q);
               addr_d  = owner_d ? DAddr : IAddr;
               unc     = owner_d ? DUncache : IUncache;
               exp_d   = unc ? 4'd1 : (owner_d ? 4'(DLINE_BEATS) : 4'(ILINE_BEATS));
               cnt_d   = '0;
               err_d   = 1'b0;
               buf_d   = '0;
               state_d = ARREQ;
            end
         end
         ARREQ: begin
            if (Arready) begin
               last_d  = owner_q;
               state_d = RDATA;
            end
         end
         RDATA: begin
            if (Rvalid) begin
               if (cnt_q < exp_q) begin
                  buf_d[cnt_q[2:0]] = Rdata;
                  cnt_d             = cnt_q + 4'd1;
               end else begin
                  err_d = 1'b1;
               end
               if (Rresp != 2'b00 || Rid != own_id) err_d = 1'b1;
               if (Rlast) begin
                  if ({1'b0, cnt_q} + 5'd1 != {1'b0, exp_q}) err_d = 1'b1;
                  state_d = RESP;
               end
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Rest) begin
      if (Rest) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         addr_q  <= '0;
         exp_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         exp_q   <= exp_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         buf_q   <= buf_d;
      end
   end

   assign Arvalid    = (state_q == ARREQ);
   assign Araddr     = addr_q;
   assign Arid       = own_id;
   assign Arlen      = {4'b0, exp_q - 4'd1};
   assign Arsize     = 3'b010;
   assign Arburst    = 2'b01;
   assign Rready     = (state_q == RDATA);
   assign IGrant     = Arvalid & Arready & ~owner_q;
   assign DGrant     = Arvalid & Arready & owner_q;
   assign IRespValid = (state_q == RESP) & ~owner_q;
   assign DRespValid = (state_q == RESP) & owner_q;
   assign RespData   = buf_q;
   assign RespErr    = err_q;
   assign Busy       = (state_q != IDLE);

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: expected responses are queued at stimulus time and popped on RespValid.
module tb_axi_read_arbiter;

   logic         Clk, Rest;
   logic         IReq, IUncache, IGrant, IRespValid;
   logic [31:0]  IAddr;
   logic         DReq, DUncache, DGrant, DRespValid;
   logic [31:0]  DAddr;
   logic [255:0] RespData;
   logic         RespErr, Busy;
   logic [3:0]   Arid;
   logic [31:0]  Araddr;
   logic [7:0]   Arlen;
   logic [2:0]   Arsize;
   logic [1:0]   Arburst;
   logic         Arvalid, Arready;
   logic [3:0]   Rid;
   logic [31:0]  Rdata;
   logic [1:0]   Rresp;
   logic         Rlast, Rvalid, Rready;

   axi_read_arbiter dut (
      .Clk(Clk), .Rest(Rest),
      .IReq(IReq), .IUncache(IUncache), .IAddr(IAddr), .IGrant(IGrant), .IRespValid(IRespValid),
      .DReq(DReq), .DUncache(DUncache), .DAddr(DAddr), .DGrant(DGrant), .DRespValid(DRespValid),
      .RespData(RespData), .RespErr(RespErr), .Busy(Busy),
      .Arid(Arid), .Araddr(Araddr), .Arlen(Arlen), .Arsize(Arsize), .Arburst(Arburst),
      .Arvalid(Arvalid), .Arready(Arready),
      .Rid(Rid), .Rdata(Rdata), .Rresp(Rresp), .Rlast(Rlast), .Rvalid(Rvalid), .Rready(Rready)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      bit           is_d;
      logic [255:0] data;
      logic         err;
   } resp_t;

   resp_t q[$];
   int    vectors     = 0;
   int    miscompares = 0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // One transaction: win_d selects the expected winner; the loser (if requesting) gets a distinct address.
   task automatic txn(input bit ir, input bit dr, input bit unc, input logic [31:0] addr, input bit win_d,
                      input int nb, input int bad_beat, input int ar_wait, input logic [31:0] base);
      int    expb;
      resp_t r;
      resp_t got;
      expb = unc ? 1 : (win_d ? 4 : 8);
      IReq = ir; DReq = dr;
      IAddr    = win_d ? addr + 32'h100 : addr;
      DAddr    = win_d ? addr : addr + 32'h100;
      IUncache = win_d ? ~unc : unc;
      DUncache = win_d ? unc : ~unc;
      r.is_d = win_d;
      r.data = '0;
      for (int k = 0; k < 8; k++)
         if (k < nb && k < expb) r.data[32*k +: 32] = base + 32'(k);
      r.err = (bad_beat >= 0 && bad_beat < nb) || (nb != expb);
      q.push_back(r);
      tick();
      for (int w = 0; w < ar_wait; w++) begin
         chk("arvalid_wait", Arvalid, 1'b1);
         chk("araddr_wait", Araddr, addr);
         chk("arlen_wait", Arlen, 8'(expb - 1));
         chk("grant_wait", {IGrant, DGrant}, 2'b00);
         tick();
      end
      chk("arvalid", Arvalid, 1'b1);
      chk("araddr", Araddr, addr);
      chk("arlen", Arlen, 8'(expb - 1));
      chk("arid", Arid, win_d ? 4'd1 : 4'd0);
      chk("arsize_burst", {Arsize, Arburst}, 5'b010_01);
      Arready = 1'b1;
      #1;
      chk("grant", {IGrant, DGrant}, win_d ? 2'b01 : 2'b10);
      tick();
      Arready = 1'b0; IReq = 1'b0; DReq = 1'b0;
      for (int k = 0; k < nb; k++) begin
         Rvalid = 1'b1;
         Rdata  = base + 32'(k);
         Rid    = win_d ? 4'd1 : 4'd0;
         Rresp  = (k == bad_beat) ? 2'b10 : 2'b00;
         Rlast  = (k == nb - 1);
         chk("rready", Rready, 1'b1);
         chk("no_resp_rdata", {IRespValid, DRespValid}, 2'b00);
         tick();
      end
      Rvalid = 1'b0; Rlast = 1'b0; Rresp = 2'b00;
      if (q.size() == 0) begin
         vectors++; miscompares++;
         $error("FAIL scoreboard_empty: observed 0 entries expected 1");
      end else begin
         got = q.pop_front();
         chk("respvalid", {IRespValid, DRespValid}, got.is_d ? 2'b01 : 2'b10);
         chk("respdata", RespData, got.data);
         chk("resperr", RespErr, got.err);
         tick();
         chk("resp_pulse_end", {IRespValid, DRespValid}, 2'b00);
         chk("busy_idle", Busy, 1'b0);
         chk("respdata_hold", RespData, got.data);
      end
   endtask

   initial begin
      Rest = 1'b1;
      IReq = 0; IUncache = 0; IAddr = '0;
      DReq = 0; DUncache = 0; DAddr = '0;
      Arready = 0; Rid = '0; Rdata = '0; Rresp = '0; Rlast = 0; Rvalid = 0;
      #1;
      chk("rst_arvalid", Arvalid, 1'b0);
      chk("rst_rready", Rready, 1'b0);
      chk("rst_busy", Busy, 1'b0);
      chk("rst_pulses", {IGrant, DGrant, IRespValid, DRespValid}, 4'b0);
      chk("rst_respdata", RespData, 256'd0);
      chk("rst_resperr", RespErr, 1'b0);
      tick(); tick();
      Rest = 1'b0;
      tick();

      // tie after reset: ICache first, then lone DCache refill, then ties alternate
      txn(1, 1, 0, 32'h1C00_0000, 0, 8, -1, 0, 32'd0);
      txn(0, 1, 0, 32'h0000_2040, 1, 4, -1, 0, 32'h100);
      txn(1, 1, 0, 32'h1C00_0100, 0, 8, -1, 0, 32'h200);
      txn(1, 1, 0, 32'h0000_3000, 1, 4, -1, 0, 32'h300);
      // uncached DCache single beat
      txn(0, 1, 1, 32'hBFAF_8000, 1, 1, -1, 0, 32'hDEAD_BEEF);
      // bad Rresp on beat 2, early Rlast, and one extra beat
      txn(0, 1, 0, 32'h0000_4000, 1, 4, 2, 0, 32'h400);
      txn(0, 1, 0, 32'h0000_5000, 1, 3, -1, 0, 32'h500);
      txn(0, 1, 0, 32'h0000_6000, 1, 5, -1, 0, 32'h600);
      // Arready held low for 5 cycles on an uncached ICache read
      txn(1, 0, 1, 32'h1FC0_0004, 0, 1, -1, 5, 32'h1234_5678);

      // reset mid-burst aborts without a response
      DReq = 1'b1; DAddr = 32'h0000_7000; DUncache = 1'b0;
      tick();
      Arready = 1'b1;
      tick();
      Arready = 1'b0; DReq = 1'b0;
      for (int k = 0; k < 2; k++) begin
         Rvalid = 1'b1; Rdata = 32'h700 + 32'(k); Rid = 4'd1; Rlast = 1'b0;
         tick();
      end
      Rvalid = 1'b0;
      chk("pre_rst_busy", Busy, 1'b1);
      Rest = 1'b1;
      #1;
      chk("midrst_rready", Rready, 1'b0);
      chk("midrst_busy", Busy, 1'b0);
      chk("midrst_resp", {IRespValid, DRespValid}, 2'b00);
      tick();
      Rest = 1'b0;
      for (int c = 0; c < 3; c++) begin
         chk("postrst_noresp", {IRespValid, DRespValid, Arvalid}, 3'b000);
         tick();
      end
      chk("scoreboard_drained", 256'(q.size()), 256'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
